my_bitscan16: RTL and testbench
===============================

Name: my_bitscan16

Overview:
- Sequential set-bit enumerator for a 16-bit word.
- The arithmetic library's 16-way OR reduction answers whether any bit is set. This block goes the other direction and reports which bits are set: it emits their indices one per handshake, lowest index first, then pulses done.
- Used by arbitration and interrupt-dispatch logic that must service every asserted request line in a deterministic order.

Parameters:
- WIDTH, 16, input word width; must be a power of two ≥ 2.
- IDXW, $clog2(WIDTH) = 4, index width; derived, not overridden.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- a, input, WIDTH, word to scan; sampled only on load acceptance.
- load, input, 1, request to start a scan of a.
- in_ready, output, 1, high when a load is accepted this cycle.
- idx, output, IDXW, index of the lowest remaining set bit.
- idx_valid, output, 1, idx is valid.
- idx_ready, input, 1, consumer accepts idx.
- done, output, 1, one-cycle pulse marking the end of a scan.
- zero, output, 1, qualifies done: the loaded word was all zeros.
- count, output, IDXW+1, number of indices emitted in the current/last scan (0..16).

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; pending = 0; count = 0.
  - idx_valid = 0; done = 0; zero = 0; idx = 0; in_ready = 1.
- States: IDLE, SCAN, FIN.
- IDLE:
  - in_ready = 1; idx_valid = 0.
  - On a cycle with load = 1: pending <= a; count <= 0; zero <= (a == 0).
  - Next state is SCAN if a ≠ 0, otherwise FIN.
  - load = 0 leaves all state unchanged.
- SCAN:
  - in_ready = 0; idx_valid = 1.
  - idx = position of the lowest 1 in pending. This is combinational from the registered pending, so first idx_valid appears the cycle after load acceptance.
  - Handshake fires when idx_valid && idx_ready. On fire: pending bit idx cleared; count <= count + 1.
  - If the cleared bit was the last 1, next state is FIN; otherwise stay in SCAN.
  - With idx_ready = 0, idx and idx_valid hold stable indefinitely; no bit is dropped.
  - Back-to-back fires allowed: one index per cycle max, so a word with k set bits drains in k cycles minimum.
- FIN:
  - Lasts exactly one cycle: done = 1, in_ready = 0, idx_valid = 0; then IDLE.
  - zero and count remain stable until the next load acceptance.
  - load asserted during SCAN or FIN is ignored; it is not queued.
- Outputs done, idx_valid, in_ready are decoded from the state register (registered state, no combinational path from load or idx_ready).
  - Exception: the pending/count update on handshake uses idx_ready in the same cycle.
- a = 0xFFFF gives 16 indices, 0..15 in order; count ends at 16, hence the IDXW+1 width.
- a changing while not in IDLE has no effect.
- Reset asserted mid-SCAN aborts immediately: no done pulse; pending cleared; outputs return to reset values asynchronously.
- Invariants: idx_valid and done are never both high. In SCAN, pending ≠ 0.

Test Plan:
- Reset then load a = 16'h8421, idx_ready held 1 → idx_valid high for 4 consecutive cycles starting the cycle after load, idx = 0, 5, 10, 15. Next cycle done = 1, zero = 0, count = 4. Then in_ready = 1.
- Load a = 16'h0000 → no idx_valid. Cycle after load: done = 1, zero = 1, count = 0. Following cycle: in_ready = 1.
- Load a = 16'hFFFF with idx_ready toggling 1,0,1,0,… → idx stable while stalled. Exactly 16 indices, 0..15, emitted over 31 cycles. done pulses once; count = 16.
- Load 16'h0003, then assert load with a = 16'hFFFF during SCAN → second load ignored. Only idx 0, 1 emitted; done; count = 2.
- Load 16'h00F0, accept idx 4, then pulse rst for half a cycle mid-SCAN → idx_valid drops without waiting for a clock edge. No done pulse; count = 0, in_ready = 1. A following load of 16'h0100 yields a single idx 8.
- Back-to-back scans: load 16'h0001, then load 16'h8000 in the first IDLE cycle after done → indices 0 then 15. Two done pulses separated by exactly 2 cycles (IDLE, SCAN).

Source files
------------

// File: rtl/my_bitscan16.sv
// my_bitscan16: sequential set-bit enumerator.
// Loads a WIDTH-bit word and hands out the index of every set bit, lowest
// first, one per idx_valid/idx_ready handshake, then pulses done for one cycle.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   a         - word to scan, sampled only when a load is accepted
//   load      - start a scan of a (honoured only while in_ready is high)
//   in_ready  - block is idle and will accept load this cycle
//   idx       - index of the lowest remaining set bit
//   idx_valid - idx is valid
//   idx_ready - consumer accepts idx
//   done      - one-cycle end-of-scan pulse
//   zero      - the last loaded word was all zeros (stable until next load)
//   count     - indices emitted in the current/last scan (0..WIDTH)
module my_bitscan16 #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned IDXW  = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WIDTH-1:0] a,
  input  logic            load,
  output logic            in_ready,
  output logic [IDXW-1:0] idx,
  output logic            idx_valid,
  input  logic            idx_ready,
  output logic            done,
  output logic            zero,
  output logic [IDXW:0]   count
);

  localparam int unsigned CNTW = IDXW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             zero_q, zero_d;

  logic [IDXW-1:0]  idx_c;
  logic [WIDTH-1:0] pending_cleared_c;

  // Lowest set bit of pending; scanning downward lets the lowest hit win.
  always_comb begin
    idx_c = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        idx_c = IDXW'(i);
      end
    end
  end

  // x & (x - 1) drops exactly the lowest set bit, i.e. bit idx_c.
  assign pending_cleared_c = pending_q & (pending_q - WIDTH'(1));

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    zero_d    = zero_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          pending_d = a;
          count_d   = '0;
          zero_d    = (a == '0);
          state_d   = (a != '0) ? S_SCAN : S_FIN;
        end
      end
      S_SCAN: begin
        if (idx_ready) begin
          pending_d = pending_cleared_c;
          count_d   = count_q + CNTW'(1);
          if (pending_cleared_c == '0) begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      count_q   <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      zero_q    <= zero_d;
    end
  end

  // Handshake/status outputs are pure decodes of the state register.
  assign in_ready  = (state_q == S_IDLE);
  assign idx_valid = (state_q == S_SCAN);
  assign done      = (state_q == S_FIN);
  assign idx       = idx_c;
  assign zero      = zero_q;
  assign count     = count_q;

endmodule

// File: tb/tb_my_bitscan16.sv
// Testbench for my_bitscan16: directed and randomized scans checked against a
// queue-of-expected-indices reference model.
module tb_my_bitscan16;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic        load;
  logic        in_ready;
  logic [3:0]  idx;
  logic        idx_valid;
  logic        idx_ready;
  logic        done;
  logic        zero;
  logic [4:0]  count;

  int checks;
  int errors;
  int cyc;

  my_bitscan16 dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .load      (load),
    .in_ready  (in_ready),
    .idx       (idx),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .done      (done),
    .zero      (zero),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One complete scan from IDLE. mode: 0 = always ready, 1 = ready toggling
  // 1,0,1,0..., 2 = random ready. inject holds load with a=FFFF while busy.
  // lat = cycles from load acceptance to the done cycle; done_cyc = global cycle of done.
  task automatic do_scan(input logic [15:0] w, input int mode, input bit inject,
                         output int lat, output int done_cyc);
    int  q[$];
    int  n;
    int  budget;
    bit  seen_done;
    bit  rdy;
    for (int b = 0; b < 16; b++) begin
      if (w[b]) q.push_back(b);
    end
    n = q.size();
    chk("in_ready_before_load", in_ready, 1);
    a    = w;
    load = 1'b1;
    step();
    load = inject;
    a    = inject ? 16'hFFFF : 16'($urandom());
    budget    = 0;
    seen_done = 1'b0;
    lat       = -1;
    done_cyc  = -1;
    while (!seen_done && budget < 200) begin
      chk("idx_valid", idx_valid, q.size() != 0);
      chk("in_ready_busy", in_ready, 0);
      chk("done", done, q.size() == 0);
      if (q.size() != 0) begin
        chk("idx", idx, q[0]);
        if (mode == 0)      rdy = 1'b1;
        else if (mode == 1) rdy = (budget % 2 == 0);
        else                rdy = 1'($urandom_range(0, 1));
        idx_ready = rdy;
        if (rdy) void'(q.pop_front());
        if (!inject) a = 16'($urandom());
      end else begin
        seen_done = 1'b1;
        lat       = budget;
        done_cyc  = cyc;
        chk("zero_at_done", zero, w == 16'h0);
        chk("count_at_done", count, n);
        idx_ready = 1'($urandom_range(0, 1));
      end
      step();
      budget++;
    end
    checks++;
    assert (seen_done) else begin
      errors++;
      $error("FAIL done_timeout: observed no done within %0d cycles expected done", budget);
    end
    load      = 1'b0;
    idx_ready = 1'b0;
    chk("in_ready_after_done", in_ready, 1);
    chk("idx_valid_after_done", idx_valid, 0);
    chk("done_after_done", done, 0);
    chk("count_held", count, n);
    chk("zero_held", zero, w == 16'h0);
  endtask

  int lat;
  int dc1;
  int dc2;
  logic [15:0] w;

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst       = 1'b1;
    load      = 1'b0;
    a         = 16'h0;
    idx_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idx_valid", idx_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_zero", zero, 0);
    chk("rst_idx", idx, 0);
    chk("rst_count", count, 0);
    rst = 1'b0;
    step();

    // 8421 with ready held: four consecutive indices then done
    do_scan(16'h8421, 0, 1'b0, lat, dc1);
    chk("lat_8421", lat, 4);

    // All-zero word: done right after load, zero set
    do_scan(16'h0000, 0, 1'b0, lat, dc1);
    chk("lat_zero", lat, 0);

    // FFFF with toggling ready: 16 indices over 31 cycles
    do_scan(16'hFFFF, 1, 1'b0, lat, dc1);
    chk("lat_ffff_toggle", lat, 31);

    // Load during SCAN/FIN is ignored
    do_scan(16'h0003, 0, 1'b1, lat, dc1);
    chk("lat_0003_inject", lat, 2);
    step();
    chk("no_queued_load_valid", idx_valid, 0);
    chk("no_queued_load_ready", in_ready, 1);

    // Asynchronous reset mid-SCAN
    a    = 16'h00F0;
    load = 1'b1;
    step();
    load      = 1'b0;
    idx_ready = 1'b1;
    chk("mid_idx4_valid", idx_valid, 1);
    chk("mid_idx4", idx, 4);
    step();
    idx_ready = 1'b0;
    chk("mid_idx5", idx, 5);
    chk("mid_count1", count, 1);
    rst = 1'b1;
    #1;
    chk("arst_idx_valid", idx_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_done", done, 0);
    chk("arst_count", count, 0);
    chk("arst_idx", idx, 0);
    #4;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    chk("post_rst_done", done, 0);
    chk("post_rst_in_ready", in_ready, 1);
    do_scan(16'h0100, 0, 1'b0, lat, dc1);
    chk("lat_0100", lat, 1);

    // Back-to-back scans: done pulses three cycles apart
    do_scan(16'h0001, 0, 1'b0, lat, dc1);
    do_scan(16'h8000, 0, 1'b0, lat, dc2);
    chk("done_gap", dc2 - dc1, 3);

    // Randomized words and random consumer stalls
    for (int t = 0; t < 24; t++) begin
      w = 16'($urandom());
      if (t % 3 == 1) w = w & 16'($urandom()) & 16'($urandom());
      if (t == 5) w = 16'h0;
      do_scan(w, 2, 1'(t % 4 == 3), lat, dc1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
